mutative_tag_ctrl: RTL and testbench



---
 rtl/mutative_tag_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mutative_tag_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mutative_tag_ctrl.sv
// Port controller for the mutative-cache tag SRAM: round-robin lookup/update
// arbitration, full-array init sweep after reset and flush, registered read return.
module mutative_tag_ctrl #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 21,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lk_req,
   input  logic [ADDR_WIDTH-1:0] lk_addr,
   output logic                  lk_gnt,
   output logic                  lk_rvalid,
   output logic [DATA_WIDTH-1:0] lk_rdata,
   input  logic                  up_req,
   input  logic [ADDR_WIDTH-1:0] up_addr,
   input  logic [DATA_WIDTH-1:0] up_wdata,
   output logic                  up_gnt,
   input  logic                  flush_req,
   output logic                  busy,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_WIDTH-1:0] cnt_r;
   logic [ADDR_WIDTH-1:0] addr_hold_r;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic [DATA_WIDTH-1:0] din_hold_r;
   logic [DATA_WIDTH-1:0] din_s;
   logic [DATA_WIDTH-1:0] lk_rdata_r;
   logic                  last_up_r;
   logic                  rd_pend_r;
   logic                  lk_rvalid_r;
   logic                  lk_gnt_s;
   logic                  up_gnt_s;
   logic                  csb_s;
   logic                  web_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_START;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_START: state_s = ST_INIT;
         ST_INIT: begin
            if (cnt_r == CNT_LAST) state_s = ST_RUN;
            else                   state_s = ST_INIT;
         end
         ST_RUN: begin
            if (flush_req) state_s = ST_INIT;
            else           state_s = ST_RUN;
         end
         default: state_s = ST_START;
      endcase
   end

   // Output logic: grants and SRAM command; idle cycles keep the last address/data on the bus
   always_comb begin
      lk_gnt_s = 1'b0;
      up_gnt_s = 1'b0;
      csb_s    = 1'b1;
      web_s    = 1'b1;
      addr_s   = addr_hold_r;
      din_s    = din_hold_r;
      case (state_r)
         ST_INIT: begin
            csb_s  = 1'b0;
            web_s  = 1'b0;
            addr_s = cnt_r;
            din_s  = INIT_VALUE;
         end
         ST_RUN: begin
            if (lk_req && (!up_req || last_up_r)) begin
               lk_gnt_s = 1'b1;
               csb_s    = 1'b0;
               addr_s   = lk_addr;
            end else if (up_req) begin
               up_gnt_s = 1'b1;
               csb_s    = 1'b0;
               web_s    = 1'b0;
               addr_s   = up_addr;
               din_s    = up_wdata;
            end else begin
               csb_s  = 1'b1;
               web_s  = 1'b1;
               addr_s = addr_hold_r;
               din_s  = din_hold_r;
            end
         end
         default: begin
            csb_s  = 1'b1;
            web_s  = 1'b1;
            addr_s = addr_hold_r;
            din_s  = din_hold_r;
         end
      endcase
   end

   // Sweep counter, round-robin pointer and SRAM bus hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= {ADDR_WIDTH{1'b0}};
         last_up_r   <= 1'b1;
         addr_hold_r <= {ADDR_WIDTH{1'b0}};
         din_hold_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         if (state_r == ST_INIT) cnt_r <= cnt_r + 1'b1;
         else                    cnt_r <= {ADDR_WIDTH{1'b0}};
         if (lk_gnt_s)      last_up_r <= 1'b0;
         else if (up_gnt_s) last_up_r <= 1'b1;
         else               last_up_r <= last_up_r;
         addr_hold_r <= addr_s;
         din_hold_r  <= din_s;
      end
   end

   // Read return: SRAM dout is only valid around the edge after the access, so capture it there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_r   <= 1'b0;
         lk_rvalid_r <= 1'b0;
         lk_rdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_pend_r   <= lk_gnt_s;
         lk_rvalid_r <= rd_pend_r;
         if (rd_pend_r) lk_rdata_r <= sram_dout;
         else           lk_rdata_r <= lk_rdata_r;
      end
   end

   assign lk_gnt    = lk_gnt_s;
   assign up_gnt    = up_gnt_s;
   assign lk_rvalid = lk_rvalid_r;
   assign lk_rdata  = lk_rdata_r;
   assign busy      = (state_r != ST_RUN);
   assign sram_csb  = csb_s;
   assign sram_web  = web_s;
   assign sram_addr = addr_s;
   assign sram_din  = din_s;

endmodule

// File: tb/tb_mutative_tag_ctrl.sv
// Self-checking bench for mutative_tag_ctrl: behavioural tag SRAM plus a read scoreboard.
module tb_mutative_tag_ctrl;
   localparam int AW = 7;
   localparam int DW = 21;
   localparam logic [DW-1:0] INIT_V = 21'h000000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          lk_req = 1'b0;
   logic [AW-1:0] lk_addr = 7'd0;
   logic          lk_gnt;
   logic          lk_rvalid;
   logic [DW-1:0] lk_rdata;
   logic          up_req = 1'b0;
   logic [AW-1:0] up_addr = 7'd0;
   logic [DW-1:0] up_wdata = 21'd0;
   logic          up_gnt;
   logic          flush_req = 1'b0;
   logic          busy;
   logic          sram_csb;
   logic          sram_web;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout = 21'd0;

   int err_cnt = 0;
   int chk_cnt = 0;
   int cyc = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } rd_exp_t;
   rd_exp_t sb_q[$];
   rd_exp_t mon_e;

   logic [DW-1:0] ref_mem [128];
   logic [DW-1:0] sram_mem [128];
   logic          csb_l = 1'b1;
   logic          web_l = 1'b1;
   logic [AW-1:0] addr_l = 7'd0;
   logic [DW-1:0] din_l = 21'd0;

   mutative_tag_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .INIT_VALUE(INIT_V)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .lk_req(lk_req),
      .lk_addr(lk_addr),
      .lk_gnt(lk_gnt),
      .lk_rvalid(lk_rvalid),
      .lk_rdata(lk_rdata),
      .up_req(up_req),
      .up_addr(up_addr),
      .up_wdata(up_wdata),
      .up_gnt(up_gnt),
      .flush_req(flush_req),
      .busy(busy),
      .sram_csb(sram_csb),
      .sram_web(sram_web),
      .sram_addr(sram_addr),
      .sram_din(sram_din),
      .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: inputs registered at posedge, array access on the following negedge
   always @(posedge clk) begin
      csb_l  <= sram_csb;
      web_l  <= sram_web;
      addr_l <= sram_addr;
      din_l  <= sram_din;
   end

   always @(negedge clk) begin
      if (!csb_l) begin
         if (!web_l) sram_mem[addr_l] <= din_l;
         else        sram_dout <= sram_mem[addr_l];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: writes update the reference image, grants push, rvalid pops
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         check_val("one_gnt", 32'({lk_gnt, up_gnt} == 2'b11), 32'd0);
         if (up_gnt) ref_mem[up_addr] = up_wdata;
         if (lk_gnt) sb_q.push_back('{ref_mem[lk_addr], cyc + 2});
         if (lk_rvalid) begin
            check_val("rvalid_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check_val("rdata", 32'(lk_rdata), 32'(mon_e.data));
               check_val("rd_latency_cyc", 32'(cyc), 32'(mon_e.cyc));
            end
         end
      end
   end

   task automatic drive(input logic lk, input logic [AW-1:0] la, input logic up,
                        input logic [AW-1:0] ua, input logic [DW-1:0] ud, input logic fl);
      @(negedge clk);
      lk_req    = lk;
      lk_addr   = la;
      up_req    = up;
      up_addr   = ua;
      up_wdata  = ud;
      flush_req = fl;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 7'd0, 1'b0, 7'd0, 21'd0, 1'b0);
   endtask

   task automatic rst_check();
      check_val("rst_ctrl", 32'({busy, lk_gnt, up_gnt, lk_rvalid, sram_csb, sram_web}), 32'b100011);
      check_val("rst_addr", 32'(sram_addr), 32'd0);
      check_val("rst_din", 32'(sram_din), 32'd0);
      check_val("rst_rdata", 32'(lk_rdata), 32'd0);
   endtask

   // Checks n cycles of {busy,csb,web,addr,din}: START first, then one INIT write per cycle
   task automatic sweep_chk(input int n);
      for (int i = 0; i < n; i++) begin
         if (i == 0)
            check_val("sweep_start", 32'({busy, sram_csb, sram_web, sram_addr, sram_din}),
                      32'({1'b1, 1'b1, 1'b1, 7'd0, 21'd0}));
         else
            check_val("sweep_init", 32'({busy, sram_csb, sram_web, sram_addr, sram_din}),
                      32'({1'b1, 1'b0, 1'b0, 7'(i - 1), INIT_V}));
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_ref();
      for (int i = 0; i < 128; i++) ref_mem[i] = INIT_V;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) sram_mem[i] = 21'h15A5A5 ^ 21'(i);
      clear_ref();
      repeat (3) @(negedge clk);
      #1;
      rst_check();

      // Power-on sweep
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      sweep_chk(129);
      check_val("run_idle", 32'({busy, sram_csb, sram_web}), 32'b011);

      // Held conflict: lookup wins first, then strict alternation
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 7'd9, 1'b1, 7'd9, 21'h00F0F0, 1'b0);
         check_val("rr_gnt", 32'({lk_gnt, up_gnt}), (i % 2 == 0) ? 32'b10 : 32'b01);
      end
      idle(3);

      // Single lookup of a swept entry
      drive(1'b1, 7'd5, 1'b0, 7'd0, 21'd0, 1'b0);
      check_val("lk5_gnt", 32'({lk_gnt, sram_csb, sram_web, sram_addr}), 32'({1'b1, 1'b0, 1'b1, 7'd5}));
      idle(3);

      // Write then read same index on the next cycle
      drive(1'b0, 7'd0, 1'b1, 7'h12, 21'h1ABCDE, 1'b0);
      check_val("wr12_cmd", 32'({up_gnt, sram_csb, sram_web, sram_addr}), 32'({1'b1, 1'b0, 1'b0, 7'h12}));
      check_val("wr12_din", 32'(sram_din), 32'h1ABCDE);
      drive(1'b1, 7'h12, 1'b0, 7'd0, 21'd0, 1'b0);
      check_val("rd12_gnt", 32'(lk_gnt), 32'd1);
      idle(2);
      check_val("idle_hold", 32'({sram_csb, sram_web, sram_addr}), 32'({1'b1, 1'b1, 7'h12}));
      idle(2);

      // Back-to-back lookups
      drive(1'b0, 7'd0, 1'b1, 7'd1, 21'h11, 1'b0);
      drive(1'b0, 7'd0, 1'b1, 7'd2, 21'h22, 1'b0);
      drive(1'b0, 7'd0, 1'b1, 7'd3, 21'h33, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 7'(i), 1'b0, 7'd0, 21'd0, 1'b0);
         check_val("b2b_gnt", 32'(lk_gnt), 32'd1);
      end
      idle(4);

      // Flush with nonzero entries and a read in the flush cycle
      drive(1'b0, 7'd0, 1'b1, 7'd0, 21'h155555, 1'b0);
      drive(1'b0, 7'd0, 1'b1, 7'd127, 21'h0AAAAA, 1'b0);
      drive(1'b1, 7'd0, 1'b0, 7'd0, 21'd0, 1'b1);
      check_val("flush_rd_gnt", 32'(lk_gnt), 32'd1);
      for (int i = 0; i < 128; i++) begin
         drive(1'b1, 7'h33, 1'b1, 7'h44, 21'h1, 1'b0);
         if (i == 0) clear_ref();
         check_val("flush_busy", 32'({busy, lk_gnt, up_gnt}), 32'b100);
      end
      drive(1'b0, 7'd0, 1'b0, 7'd0, 21'd0, 1'b0);
      check_val("flush_done", 32'(busy), 32'd0);
      drive(1'b1, 7'd0, 1'b0, 7'd0, 21'd0, 1'b0);
      drive(1'b1, 7'd127, 1'b0, 7'd0, 21'd0, 1'b0);
      idle(4);

      // Reset during a pending read, then during a sweep
      drive(1'b0, 7'd0, 1'b1, 7'd7, 21'h1FFFFF, 1'b0);
      drive(1'b1, 7'd7, 1'b0, 7'd0, 21'd0, 1'b0);
      idle(3);
      drive(1'b1, 7'd7, 1'b0, 7'd0, 21'd0, 1'b0);
      @(negedge clk);
      rst_n  = 1'b0;
      lk_req = 1'b0;
      sb_q.delete();
      #1;
      rst_check();
      @(negedge clk);
      rst_n = 1'b1;
      clear_ref();
      #1;
      sweep_chk(61);
      check_val("sweep_at60", 32'({sram_csb, sram_web, sram_addr}), 32'({1'b0, 1'b0, 7'd60}));
      rst_n = 1'b0;
      #1;
      rst_check();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      sweep_chk(129);
      check_val("resweep_done", 32'(busy), 32'd0);
      drive(1'b1, 7'd127, 1'b0, 7'd0, 21'd0, 1'b0);
      idle(1);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      #3;
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
